vec_compare_unit: RTL and testbench

- Parametrised, pipelined successor to the scalar branch comparison unit; evaluates one of six RV32I branch conditions across LANES independent DATA_W-bit lane pairs.
- Produces a per-lane result mask plus any/all reductions; lane 0 gives the scalar branch decision.
- Sits between the register-read stage and branch/predication logic of the vector datapath; ready/valid handshake on both sides.
- Keeps a saturating count of transfers with at least one passing lane.

---
 rtl/vec_compare_unit.sv | 159 +++++++++++++++
 tb/tb_vec_compare_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vec_compare_unit.sv
// vec_compare_unit: evaluates one RV32I branch condition across LANES lane
// pairs. It produces a per-lane pass mask, any/all reductions, a scalar
// taken bit (lane 0) and a saturating count of passing results.
// Latency is 2 cycles from input transfer to out_valid. Throughput is 1 result per cycle.
// Backpressure: S2 freezes while out_valid=1 and out_ready=0. S1 holds when it
// is full behind a frozen S2. in_ready is combinational from out_ready and
// there is no skid buffer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   cond                0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6/7 illegal
//   a, b                packed operands, lane i at [i*DATA_W +: DATA_W]
//   lane_en             per-lane enable
//   out_valid/out_ready result handshake
//   out_mask/any/all    per-lane result and reductions
//   out_taken, out_err  lane 0 decision, illegal-cond flag
//   hit_cnt, cnt_clr    saturating passing-result counter and its clear
module vec_compare_unit #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              cond,
  input  logic [LANES*DATA_W-1:0] a,
  input  logic [LANES*DATA_W-1:0] b,
  input  logic [LANES-1:0]        lane_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_mask,
  output logic                    out_any,
  output logic                    out_all,
  output logic                    out_taken,
  output logic                    out_err,
  output logic [CNT_W-1:0]        hit_cnt,
  input  logic                    cnt_clr
);

  // Stage 1 registers: the raw request.
  logic                    r_s1_valid;
  logic [LANES*DATA_W-1:0] r_s1_a;
  logic [LANES*DATA_W-1:0] r_s1_b;
  logic [2:0]              r_s1_cond;
  logic [LANES-1:0]        r_s1_en;

  // Stage 2 registers: the finished result, which drives the outputs directly.
  logic                    r_s2_valid;
  logic [LANES-1:0]        r_s2_mask;
  logic                    r_s2_any;
  logic                    r_s2_all;
  logic                    r_s2_err;
  logic [CNT_W-1:0]        r_hit_cnt;

  logic                    w_s1_adv;
  logic                    w_s2_adv;
  logic                    w_out_xfer;
  logic [LANES-1:0]        w_eq;
  logic [LANES-1:0]        w_lts;
  logic [LANES-1:0]        w_ltu;
  logic [LANES-1:0]        w_hit;
  logic [LANES-1:0]        w_mask;
  logic                    w_err;
  logic                    w_any;
  logic                    w_all;

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_out_xfer = r_s2_valid && out_ready;
  assign in_ready   = w_s1_adv;

  // Raw per-lane relations. GE/GEU/NE are formed later by inversion, so each
  // one is an exact complement of its partner.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_W-1:0] w_la;
    logic [DATA_W-1:0] w_lb;
    assign w_la      = r_s1_a[gi*DATA_W +: DATA_W];
    assign w_lb      = r_s1_b[gi*DATA_W +: DATA_W];
    assign w_eq[gi]  = (w_la == w_lb);
    assign w_lts[gi] = ($signed(w_la) < $signed(w_lb));
    assign w_ltu[gi] = (w_la < w_lb);
  end

  always_comb begin
    w_hit = '0;
    w_err = 1'b0;
    case (r_s1_cond)
      3'd0:    w_hit = w_eq;
      3'd1:    w_hit = ~w_eq;
      3'd2:    w_hit = w_lts;
      3'd3:    w_hit = ~w_lts;
      3'd4:    w_hit = w_ltu;
      3'd5:    w_hit = ~w_ltu;
      default: w_err = 1'b1;
    endcase
    // Disabled lanes always report 0.
    w_mask = w_hit & r_s1_en;
    w_any  = |w_mask;
    // A result with no enabled lanes is not vacuously "all passed".
    w_all  = !w_err && (|r_s1_en) && (w_mask == r_s1_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cond  <= '0;
      r_s1_en    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a    <= a;
        r_s1_b    <= b;
        r_s1_cond <= cond;
        r_s1_en   <= lane_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_mask  <= '0;
      r_s2_any   <= 1'b0;
      r_s2_all   <= 1'b0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mask <= w_mask;
        r_s2_any  <= w_any;
        r_s2_all  <= w_all;
        r_s2_err  <= w_err;
      end
    end
  end

  // The clear wins over a same-cycle increment. The counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_hit_cnt <= '0;
    end else if (w_out_xfer && r_s2_any && !(&r_hit_cnt)) begin
      r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_mask  = r_s2_mask;
  assign out_any   = r_s2_any;
  assign out_all   = r_s2_all;
  assign out_taken = r_s2_mask[0];
  assign out_err   = r_s2_err;
  assign hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_vec_compare_unit.sv
module tb_vec_compare_unit;
  localparam int DW = 32;
  localparam int LN = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [2:0]      cond;
  logic [LN*DW-1:0] a;
  logic [LN*DW-1:0] b;
  logic [LN-1:0]   lane_en;
  logic            out_ready;
  logic            cnt_clr;

  logic            in_ready, out_valid, out_any, out_all, out_taken, out_err;
  logic [LN-1:0]   out_mask;
  logic [15:0]     hit_cnt;

  logic            s_in_ready, s_out_valid, s_out_any, s_out_all, s_out_taken, s_out_err;
  logic [LN-1:0]   s_out_mask;
  logic [1:0]      s_hit_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  vec_compare_unit #(.DATA_W(DW), .LANES(LN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .a(a), .b(b), .lane_en(lane_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_any(out_any), .out_all(out_all), .out_taken(out_taken),
    .out_err(out_err), .hit_cnt(hit_cnt), .cnt_clr(cnt_clr)
  );

  // Narrow-counter copy driven by the same stimulus, used for saturation.
  vec_compare_unit #(.DATA_W(DW), .LANES(LN), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .cond(cond), .a(a), .b(b), .lane_en(lane_en),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_mask(s_out_mask),
    .out_any(s_out_any), .out_all(s_out_all), .out_taken(s_out_taken),
    .out_err(s_out_err), .hit_cnt(s_hit_cnt), .cnt_clr(cnt_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for one cycle, then wait so that the result sits in S2.
  task automatic issue(input logic [2:0] c, input logic [LN-1:0] en);
    cond = c; lane_en = en; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic chk_res(input string tag, input logic [3:0] m, input logic an,
                         input logic al, input logic er);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".mask"},  out_mask, m);
    chk({tag, ".any"},   out_any, an);
    chk({tag, ".all"},   out_all, al);
    chk({tag, ".taken"}, out_taken, m[0]);
    chk({tag, ".err"},   out_err, er);
  endtask

  logic [LN*DW-1:0] opa, opb, eqv;

  initial begin
    // Lane 0 is the least significant word.
    // lane0 -1 vs 0, lane1 5 vs 5, lane2 0x7FFFFFFF vs 0x80000000, lane3 3 vs 4.
    opa = {32'd3, 32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF};
    opb = {32'd4, 32'h8000_0000, 32'd5, 32'h0000_0000};
    eqv = {32'hDEAD_BEEF, 32'h8000_0000, 32'd0, 32'h1234_5678};

    rst = 1'b1; in_valid = 1'b0; cond = '0; a = '0; b = '0;
    lane_en = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.mask", out_mask, 4'b0000);
    chk("rst.err", out_err, 1'b0);
    chk("rst.cnt", hit_cnt, 16'd0);

    a = opa; b = opb;
    issue(3'd2, 4'b1111); chk_res("lt", 4'b1001, 1, 0, 0);
    step(); chk("lt.drain", out_valid, 1'b0); chk("lt.cnt", hit_cnt, 16'd1);
    issue(3'd3, 4'b1111); chk_res("ge", 4'b0110, 1, 0, 0);
    step(); chk("ge.cnt", hit_cnt, 16'd2);
    issue(3'd1, 4'b1111); chk_res("ne", 4'b1101, 1, 0, 0);
    step(); chk("ne.cnt", hit_cnt, 16'd3);
    chk("ne.scnt", s_hit_cnt, 2'd3);
    issue(3'd4, 4'b1111); chk_res("ltu", 4'b1100, 1, 0, 0);
    step(); chk("ltu.cnt", hit_cnt, 16'd4);
    chk("sat.scnt4", s_hit_cnt, 2'd3);
    issue(3'd5, 4'b1111); chk_res("geu", 4'b0011, 1, 0, 0);
    step(); chk("sat.scnt5", s_hit_cnt, 2'd3);

    a = eqv; b = eqv;
    issue(3'd0, 4'b0101); chk_res("eq_part", 4'b0101, 1, 1, 0);
    step(); chk("eq_part.cnt", hit_cnt, 16'd6);
    issue(3'd0, 4'b0000); chk_res("eq_none", 4'b0000, 0, 0, 0);
    step(); chk("eq_none.cnt", hit_cnt, 16'd6);
    issue(3'd7, 4'b1111); chk_res("illegal", 4'b0000, 0, 0, 1);
    step(); chk("illegal.cnt", hit_cnt, 16'd6);

    // Stall: three requests A/B/C with distinct single-lane masks.
    out_ready = 1'b0; cond = 3'd0; in_valid = 1'b1;
    lane_en = 4'b0001; step();
    chk("stall.rdy1", in_ready, 1'b1);
    lane_en = 4'b0010; step();
    lane_en = 4'b0100;
    chk("stall.rdy_drop", in_ready, 1'b0);
    chk("stall.A0", out_mask, 4'b0001);
    step();
    chk("stall.A1", out_mask, 4'b0001);
    chk("stall.v1", out_valid, 1'b1);
    step();
    chk("stall.A2", out_mask, 4'b0001);
    chk("stall.rdy2", in_ready, 1'b0);
    out_ready = 1'b1;
    #1 chk("stall.rdy_rel", in_ready, 1'b1);
    step(); in_valid = 1'b0;
    chk("order.B", out_mask, 4'b0010);
    step();
    chk("order.C", out_mask, 4'b0100);
    chk("order.Cv", out_valid, 1'b1);
    step();
    chk("order.drain", out_valid, 1'b0);
    chk("order.cnt", hit_cnt, 16'd9);

    // A clear coinciding with a passing transfer wins.
    issue(3'd0, 4'b1111);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("clr.cnt", hit_cnt, 16'd0);
    chk("clr.scnt", s_hit_cnt, 2'd0);
    issue(3'd0, 4'b1111); step();
    chk("pre_rst.cnt", hit_cnt, 16'd1);

    // Reset with two requests in flight behind a stalled output.
    out_ready = 1'b0; in_valid = 1'b1; lane_en = 4'b1000;
    step(); step();
    in_valid = 1'b0;
    chk("full.rdy", in_ready, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst.valid", out_valid, 1'b0);
    chk("mrst.cnt", hit_cnt, 16'd0);
    chk("mrst.mask", out_mask, 4'b0000);
    chk("mrst.rdy", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mrst.no_stale", out_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
